// File: rtl/bmf_pkg.sv
// Shared types and helpers for the BMF decompressor family.
// Holds the search FSM encoding, the popcount helper and the basis row type.
package bmf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } bmf_state_e;

    // Widest row any checker uses. Narrower rows are zero-extended into it.
    localparam int BMF_M_MAX = 16;

    typedef logic [BMF_M_MAX-1:0] bmf_row_t;

    function automatic logic [4:0] popcount16(input bmf_row_t v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < BMF_M_MAX; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bmf_row_decode.sv
// Combinational BMF decompressor: ORs together every basis row selected by a latent code.
module bmf_row_decode #(
    parameter int K = 4,
    parameter int M = 5
) (
    input  logic [K-1:0][M-1:0] h,
    input  logic [K-1:0]        code,
    output logic [M-1:0]        dec
);

    always_comb begin
        dec = '0;
        for (int j = 0; j < K; j++) begin
            if (code[j]) begin
                dec = dec | h[j];
            end
        end
    end

endmodule

// File: rtl/bmf_latent_search.sv
// Exhaustive latent-code search: finds the code whose decoded vector is closest in Hamming
// distance to a target, one candidate per cycle through a two-stage (decode, compare) pipeline.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid
// never depends on ready, and a raised valid holds its payload until that transfer.
module bmf_latent_search
    import bmf_pkg::*;
#(
    parameter  int K  = 4,
    parameter  int M  = 5,
    localparam int DW = $clog2(M + 1),
    localparam int IW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [M-1:0]  cfg_row,
    output logic          busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M-1:0]  in_target,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_code,
    output logic [DW-1:0] out_dist,
    output logic          out_exact
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] SEARCH = ST_SEARCH;
    localparam logic [1:0] DONE   = ST_DONE;

    logic [1:0]         state;
    logic [K-1:0][M-1:0] h;
    logic [M-1:0]       target;
    logic [K:0]         cand;
    logic [M-1:0]       dec;
    logic [DW-1:0]      dist_c;

    // Stage-2 registers: distance of the candidate decoded in the previous cycle.
    logic               vld_q;
    logic [DW-1:0]      dist_q;
    logic [K-1:0]       code_q;

    logic [DW-1:0]      best_dist;
    logic [K-1:0]       best_code;
    logic               upd;
    logic [DW-1:0]      new_dist;
    logic [K-1:0]       new_code;
    logic               finish;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    bmf_row_decode #(
        .K (K),
        .M (M)
    ) u_dec (
        .h    (h),
        .code (cand[K-1:0]),
        .dec  (dec)
    );

    assign dist_c = DW'(popcount16(BMF_M_MAX'(dec ^ target)));

    // Strict less-than keeps the lower code on ties, since candidates arrive in ascending order.
    assign upd      = (dist_q < best_dist);
    assign new_dist = upd ? dist_q : best_dist;
    assign new_code = upd ? code_q : best_code;
    assign finish   = vld_q && ((dist_q == '0) || (code_q == {K{1'b1}}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
        end else if (cfg_we && (state == IDLE) && (int'({1'b0, cfg_idx}) < K)) begin
            h[cfg_idx] <= cfg_row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            target    <= '0;
            cand      <= '0;
            vld_q     <= 1'b0;
            dist_q    <= '0;
            code_q    <= '0;
            best_dist <= '1;
            best_code <= '0;
            out_code  <= '0;
            out_dist  <= '0;
            out_exact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        target    <= in_target;
                        cand      <= '0;
                        vld_q     <= 1'b0;
                        best_dist <= '1;
                        best_code <= '0;
                        state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (vld_q) begin
                        best_dist <= new_dist;
                        best_code <= new_code;
                    end
                    if (finish) begin
                        state     <= DONE;
                        out_code  <= new_code;
                        out_dist  <= new_dist;
                        out_exact <= (new_dist == '0);
                        vld_q     <= 1'b0;
                    end else if (!cand[K]) begin
                        dist_q <= dist_c;
                        code_q <= cand[K-1:0];
                        vld_q  <= 1'b1;
                        cand   <= cand + 1'b1;
                    end else begin
                        vld_q <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmf_latent_search.sv
// Directed bench for bmf_latent_search with hand-computed codes, distances and latencies.
module tb_bmf_latent_search;

    localparam int K  = 4;
    localparam int M  = 5;
    localparam int DW = 3;

    logic          clk;
    logic          rst_n;
    logic          cfg_we;
    logic [1:0]    cfg_idx;
    logic [M-1:0]  cfg_row;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [M-1:0]  in_target;
    logic          out_valid;
    logic          out_ready;
    logic [K-1:0]  out_code;
    logic [DW-1:0] out_dist;
    logic          out_exact;

    int n_checks;
    int n_errors;

    bmf_latent_search #(
        .K (K),
        .M (M)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_row   (cfg_row),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_target (in_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_dist  (out_dist),
        .out_exact (out_exact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [M-1:0] row);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_row = row;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Issues one request and waits (bounded) for the result; leaves it un-acknowledged.
    task automatic run_case(input string tag, input logic [M-1:0] tgt,
                            input logic [K-1:0] ecode, input int edist, input logic eexact,
                            input int elat, input bit with_cfg,
                            input logic [1:0] cidx, input logic [M-1:0] crow);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        in_target = tgt;
        if (with_cfg) begin
            cfg_we  = 1'b1;
            cfg_idx = cidx;
            cfg_row = crow;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
        end
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_code"}, 32'(out_code), 32'(ecode));
        check({tag, "_dist"}, 32'(out_dist), 32'(edist));
        check({tag, "_exact"}, 32'(out_exact), 32'(eexact));
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic take_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_row   = '0;
        in_valid  = 1'b0;
        in_target = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_code", 32'(out_code), 32'd0);
        check("rst_dist", 32'(out_dist), 32'd0);
        check("rst_exact", 32'(out_exact), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        run_case("zero", 5'b00000, 4'd0, 0, 1'b1, 2, 1'b0, 2'd0, 5'd0);
        take_result("zero");

        cfg_write(2'd0, 5'b00011);
        cfg_write(2'd1, 5'b00100);
        cfg_write(2'd2, 5'b01000);
        cfg_write(2'd3, 5'b10000);

        run_case("exact5", 5'b01011, 4'b0101, 0, 1'b1, 7, 1'b0, 2'd0, 5'd0);
        take_result("exact5");

        run_case("tie", 5'b10101, 4'b1010, 1, 1'b0, 17, 1'b0, 2'd0, 5'd0);
        // Hold the result; a row-0 write here would make code 1 exact if it were taken.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cfg_we  = (i == 1);
            cfg_idx = 2'd0;
            cfg_row = 5'b10101;
            @(posedge clk);
            #1;
            cfg_we = 1'b0;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_code", 32'(out_code), 32'(4'b1010));
            check("hold_dist", 32'(out_dist), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        take_result("hold");
        run_case("rerun", 5'b10101, 4'b1010, 1, 1'b0, 17, 1'b0, 2'd0, 5'd0);
        take_result("rerun");

        @(negedge clk);
        in_valid  = 1'b1;
        in_target = 5'b10101;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_code", 32'(out_code), 32'd0);
        check("midrst_dist", 32'(out_dist), 32'd0);
        check("midrst_exact", 32'(out_exact), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(in_ready), 32'd1);
        run_case("after_rst", 5'b00001, 4'd0, 1, 1'b0, 17, 1'b0, 2'd0, 5'd0);
        take_result("after_rst");

        run_case("same_edge", 5'b00001, 4'b0001, 0, 1'b1, 3, 1'b1, 2'd0, 5'b00001);
        take_result("same_edge");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
